// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_sequencer
// Purpose  : Word-level front end that drives a single external 1-bit ALU
//            bit-serially (LSB first) to perform WIDTH-bit AND/OR/ADD
//            operations. It assembles the word result and flags, then emits
//            a one-cycle Done pulse.
// Ports    : Clk, Reset_n (async, active-low)
//            Start, A, B, Op        - operation request (sampled in IDLE)
//            Busy, Done, Err        - status (Done/Err are one-cycle pulses)
//            Result, Zero, CarryOut, Overflow - registered word outputs
//            AluA, AluB, AluCarryIn, AluOp     - drive to the 1-bit ALU
//            AluResult, AluCarryOut            - return from the 1-bit ALU
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             AluA,
  output logic             AluB,
  output logic             AluCarryIn,
  output logic [3:0]       AluOp,
  input  logic             AluResult,
  input  logic             AluCarryOut
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0]       C_OP_ADD     = 2'b10;
  localparam logic [1:0]       C_OP_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_err;

  logic             w_accept;
  logic             w_reject;
  logic             w_last;
  logic             w_is_add;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept = (r_state == S_IDLE) && Start && (Op[1:0] != C_OP_ILLEGAL);
  assign w_reject = (r_state == S_IDLE) && Start && (Op[1:0] == C_OP_ILLEGAL);
  assign w_last   = (r_cnt == C_CNT_LAST);
  assign w_is_add = (r_op[1:0] == C_OP_ADD);

  // Shift register with the current ALU bit merged in, so the final word
  // (and its zero flag) can be registered on the same edge as the last bit.
  always_comb begin
    w_shift_next        = r_shift;
    w_shift_next[r_cnt] = AluResult;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last)   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The ALU drive is silenced outside RUN.
  // --------------------------------------------------------------------------
  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    AluA       = 1'b0;
    AluB       = 1'b0;
    AluCarryIn = 1'b0;
    AluOp      = 4'b0000;
    case (r_state)
      S_RUN: begin
        Busy       = 1'b1;
        AluA       = r_a[r_cnt];
        AluB       = r_b[r_cnt];
        AluCarryIn = r_carry;
        AluOp      = r_op;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 4'b0000;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_shift     <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_op    <= Op;
        r_cnt   <= '0;
        // Seeding the carry with the invert-B bit turns ~B into -B.
        r_carry <= Op[2];
      end else if (r_state == S_RUN) begin
        r_shift <= w_shift_next;
        if (w_is_add) begin
          r_carry <= AluCarryOut;
        end
        if (w_last) begin
          r_cnt       <= '0;
          r_result    <= w_shift_next;
          r_zero      <= (w_shift_next == '0);
          r_carry_out <= w_is_add & AluCarryOut;
          // r_carry still holds the carry into the MSB on this edge.
          r_overflow  <= w_is_add & (r_carry ^ AluCarryOut);
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign Err      = r_err;
  assign Result   = r_result;
  assign Zero     = r_zero;
  assign CarryOut = r_carry_out;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_sequencer
// Purpose  : Self-checking bench for serial_alu_sequencer with a stand-in
//            1-bit ALU and a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Op;
  logic         Busy, Done, Err, Zero, CarryOut, Overflow;
  logic [W-1:0] Result;
  logic         AluA, AluB, AluCarryIn;
  logic [3:0]   AluOp;
  logic         AluResult, AluCarryOut;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_res;
  logic         last_z, last_c, last_v;

  always #5 Clk = ~Clk;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B), .Op(Op),
    .Busy(Busy), .Done(Done), .Err(Err), .Result(Result), .Zero(Zero),
    .CarryOut(CarryOut), .Overflow(Overflow), .AluA(AluA), .AluB(AluB),
    .AluCarryIn(AluCarryIn), .AluOp(AluOp), .AluResult(AluResult),
    .AluCarryOut(AluCarryOut)
  );

  // Stand-in for the external combinational 1-bit ALU.
  logic alu_ai, alu_bi;
  always_comb begin
    alu_ai      = AluA ^ AluOp[3];
    alu_bi      = AluB ^ AluOp[2];
    AluResult   = 1'b0;
    AluCarryOut = 1'b0;
    case (AluOp[1:0])
      2'b00: AluResult = alu_ai & alu_bi;
      2'b01: AluResult = alu_ai | alu_bi;
      2'b10: begin
        AluResult   = alu_ai ^ alu_bi ^ AluCarryIn;
        AluCarryOut = (alu_ai & alu_bi) | (alu_ai & AluCarryIn) | (alu_bi & AluCarryIn);
      end
      default: ;
    endcase
  end

  // Word-level reference: plain arithmetic on the (optionally inverted) operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] op, output logic [W-1:0] r,
                                output logic z, output logic c, output logic v);
    logic [W-1:0] aa, bb;
    logic [W:0]   s;
    aa = op[3] ? ~a : a;
    bb = op[2] ? ~b : b;
    c  = 1'b0;
    v  = 1'b0;
    case (op[1:0])
      2'b00:   r = aa & bb;
      2'b01:   r = aa | bb;
      default: begin
        s = {1'b0, aa} + {1'b0, bb} + (W+1)'(op[2]);
        r = s[W-1:0];
        c = s[W];
        v = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
      end
    endcase
    z = (r == '0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_result"},   32'(Result),   32'(last_res));
    check({tag, "_zero"},     32'(Zero),     32'(last_z));
    check({tag, "_carryout"}, 32'(CarryOut), 32'(last_c));
    check({tag, "_overflow"}, 32'(Overflow), 32'(last_v));
  endtask

  // One full operation; optional disturbance raises Start (with an illegal
  // op) during RUN and during the Done cycle, both of which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input bit disturb);
    logic [W-1:0] er;
    logic ez, ec, ev;
    model(a, b, op, er, ez, ec, ev);
    @(negedge Clk);
    Start = 1'b1; A = a; B = b; Op = op;
    @(posedge Clk); #1;
    check("busy_e0", 32'(Busy), 32'd1);
    check("aluop", 32'(AluOp), 32'(op));
    check("alu_cin0", 32'(AluCarryIn), 32'(op[2]));
    Start = 1'b0; A = W'($urandom); B = W'($urandom);
    for (int k = 1; k <= W + 1; k++) begin
      if (disturb && (k == 2 || k == W + 1)) begin
        Start = 1'b1; Op = 4'b0011;
      end
      if (disturb && k == 5) Start = 1'b0;
      if (k <= W) check("alu_a_bit", 32'(AluA), 32'(a[k-1]));
      @(posedge Clk); #1;
      check("busy", 32'(Busy), 32'(k < W));
      check("done", 32'(Done), 32'(k == W));
      check("err_quiet", 32'(Err), 32'd0);
      if (k == W) begin
        last_res = er; last_z = ez; last_c = ec; last_v = ev;
        check_flags("op");
      end
    end
    Start = 1'b0; Op = 4'b0010;
    @(posedge Clk); #1;
    check("idle_after", 32'(Busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ba, bb, ga, gb;
    logic [3:0]   bo, go;
    logic [W-1:0] er;
    logic ez, ec, ev;

    Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; Op = 4'b0000;
    last_res = '0; last_z = 1'b0; last_c = 1'b0; last_v = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", 32'({Busy, Done, Err, Result, Zero, CarryOut, Overflow,
                               AluA, AluB, AluCarryIn, AluOp}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed cases
    run_op(8'h3C, 8'h05, 4'b0010, 1'b0);
    run_op(8'h05, 8'h05, 4'b0110, 1'b1);
    run_op(8'h7F, 8'h01, 4'b0010, 1'b0);
    run_op(8'hF0, 8'h3C, 4'b0000, 1'b0);
    run_op(8'h0F, 8'h10, 4'b1001, 1'b1);

    // Illegal op: Err pulse only, result untouched
    @(negedge Clk);
    Start = 1'b1; Op = 4'b0011; A = 8'hAA; B = 8'h55;
    @(posedge Clk); #1;
    check("illegal_err", 32'(Err), 32'd1);
    check("illegal_busy", 32'(Busy), 32'd0);
    Start = 1'b0;
    @(posedge Clk); #1;
    check("illegal_err_end", 32'(Err), 32'd0);
    check("illegal_busy2", 32'(Busy), 32'd0);
    check_flags("illegal_hold");

    // Reset during bit 3 of an operation
    @(negedge Clk);
    Start = 1'b1; A = 8'h3C; B = 8'h05; Op = 4'b0010;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({Busy, Done, Err, Result, Zero, CarryOut, Overflow,
                                  AluA, AluB, AluCarryIn, AluOp}), 32'd0);
    repeat (3) begin
      @(posedge Clk); #1;
      check("midreset_nodone", 32'(Done), 32'd0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    last_res = '0; last_z = 1'b0; last_c = 1'b0; last_v = 1'b0;
    @(posedge Clk); #1;
    check("post_reset_nodone", 32'(Done), 32'd0);
    run_op(8'h01, 8'h01, 4'b0010, 1'b0);

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom),
             {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))}, bit'($urandom_range(0, 1)));
    end

    // Back-to-back with Start held high; operands change every cycle and only
    // the values present on each accepting edge may matter.
    @(negedge Clk);
    ba = W'($urandom); bb = W'($urandom); bo = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))};
    Start = 1'b1; A = ba; B = bb; Op = bo;
    @(posedge Clk);
    for (int n = 0; n < 4; n++) begin
      model(ba, bb, bo, er, ez, ec, ev);
      for (int k = 1; k <= W + 2; k++) begin
        @(negedge Clk);
        if (k == W + 2) begin
          ba = W'($urandom); bb = W'($urandom);
          bo = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))};
          A = ba; B = bb; Op = bo;
        end else begin
          ga = W'($urandom); gb = W'($urandom); go = 4'($urandom);
          A = ga; B = gb; Op = go;
        end
        @(posedge Clk); #1;
        check("b2b_done", 32'(Done), 32'(k == W));
        if (k == W) begin
          last_res = er; last_z = ez; last_c = ec; last_v = ev;
          check_flags("b2b");
        end
      end
    end
    @(negedge Clk);
    Start = 1'b0;
    repeat (W + 3) @(posedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
